// File: rtl/seq_mult_32x32_pkg.sv
// Shared types and widths for the sequential 32x32 multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 5;

    // Count value of the final iteration when no early exit occurs.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);
endpackage

// File: rtl/seq_mult_32x32_csel_add.sv
// 64-bit carry-select adder: each block precomputes both carry-in cases and
// the ripple of block carries only drives the selects.
module csel_add_64 #(
    parameter int W   = 64,
    parameter int BLK = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);
    localparam int NB = W / BLK;

    logic [NB:0] carry;
    assign carry[0] = c_in;

    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        logic [BLK:0] s0, s1;
        assign s0 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]};
        assign s1 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        assign sum[gi*BLK +: BLK] = carry[gi] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign carry[gi+1]        = carry[gi] ? s1[BLK]     : s0[BLK];
    end

    assign c_out = carry[NB];
endmodule

// File: rtl/seq_mult_32x32.sv
// Unsigned 32x32 shift-and-add multiplier with valid/ready on both sides,
// reusing one 64-bit carry-select adder for every partial-product add.
module seq_mult_32x32
    import mult_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product
);
    state_t              state;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   mcand;
    logic [OP_W-1:0]     mplier;
    logic [CNT_W-1:0]    count;
    logic [PROD_W-1:0]   add_sum;
    logic                add_c_out_unused;
    logic                last_iter;

    // acc never exceeds a*2^count during RUN, so the carry out stays clear.
    csel_add_64 #(.W(PROD_W), .BLK(8)) u_add (
        .a     (acc),
        .b     (mcand),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_c_out_unused)
    );

    assign last_iter = (count == CNT_LAST) ||
                       (EARLY_EXIT && ((mplier >> 1) == '0));
    assign product   = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= {{(PROD_W-OP_W){1'b0}}, a};
                        mplier   <= b;
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0])
                        acc <= add_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= (count == CNT_LAST) ? count : count + 1'b1;
                    if (last_iter) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
